// File: rtl/bcd_pkg.sv
// Shared BCD character type, digit limit and operation encoding.
// Parameter-free so any BCD block can import it regardless of its width.
package bcd_pkg;

    typedef logic [3:0] char_t;

    localparam char_t CHAR_MAX = 4'd9;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit adder/subtractor with carry (add) or borrow (subtract).
// Operands are assumed to be valid digits 0..9; cout is carry or borrow depending on op.
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  char_t a,
    input  char_t b,
    input  op_t   op,
    input  logic  cin,
    output char_t d,
    output logic  cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        // Range is -10..9, so bit 4 acts as the sign of the difference.
        diff = {1'b0, a} - {1'b0, b} - {4'b0000, cin};
        d    = '0;
        cout = 1'b0;
        if (op == OP_ADD) begin
            if (sum > 5'd9) begin
                d    = 4'(sum - 5'd10);
                cout = 1'b1;
            end else begin
                d = sum[3:0];
            end
        end else begin
            if (diff[4]) begin
                d    = 4'(diff + 5'd10);
                cout = 1'b1;
            end else begin
                d = diff[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_price_alu.sv
// Digit-serial BCD price add/subtract: one digit per cycle, least-significant cent first,
// with saturation on overflow, clamp-to-zero on underflow and invalid-digit detection.
module bcd_price_alu
    import bcd_pkg::*;
#(
    parameter int DOLLAR_N = 3,
    parameter int CENT_N   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic                           in_op,
    input  logic [4*(DOLLAR_N+CENT_N)-1:0] in_a,
    input  logic [4*(DOLLAR_N+CENT_N)-1:0] in_b,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [4*(DOLLAR_N+CENT_N)-1:0] out_result,
    output logic                           out_ovf,
    output logic                           out_unf,
    output logic                           out_err
);

    localparam int N = DOLLAR_N + CENT_N;
    localparam int W = 4 * N;

    typedef logic [W-1:0]             word_t;
    typedef logic [$clog2(N+1)-1:0]   idx_t;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam word_t ALL_NINES = {N{4'h9}};

    function automatic logic has_bad_digit(input word_t v);
        for (int i = 0; i < N; i++) begin
            if (char_t'(v[4*i +: 4]) > CHAR_MAX) return 1'b1;
        end
        return 1'b0;
    endfunction

    state_t state_q, state_d;
    word_t  a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    op_t    op_q, op_d;
    logic   c_q, c_d;
    idx_t   idx_q, idx_d;
    logic   ovf_q, ovf_d, unf_q, unf_d, err_q, err_d;

    char_t  dig;
    logic   dig_cout;
    word_t  acc_next;

    bcd_digit_addsub u_digit (
        .a   (char_t'(a_q[3:0])),
        .b   (char_t'(b_q[3:0])),
        .op  (op_q),
        .cin (c_q),
        .d   (dig),
        .cout(dig_cout)
    );

    // Result digits enter at the top and shift down, so after N steps digit 0 sits at the LSB.
    assign acc_next = {dig, acc_q[W-1:4]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_vld) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    op_d  = op_t'(in_op);
                    c_d   = 1'b0;
                    idx_d = '0;
                    acc_d = '0;
                    if (has_bad_digit(in_a) || has_bad_digit(in_b)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        res_d   = '0;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                c_d   = dig_cout;
                acc_d = acc_next;
                idx_d = idx_t'(idx_q + 1'b1);
                if (idx_q == idx_t'(N - 1)) begin
                    state_d = S_DONE;
                    if (dig_cout && op_q == OP_ADD) begin
                        res_d = ALL_NINES;
                        ovf_d = 1'b1;
                    end else if (dig_cout) begin
                        res_d = '0;
                        unf_d = 1'b1;
                    end else begin
                        res_d = acc_next;
                    end
                end
            end
            S_DONE: begin
                if (out_rdy) begin
                    state_d = S_IDLE;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    // Operand and accumulator registers are always reloaded at accept, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        op_q  <= op_d;
        c_q   <= c_d;
        idx_q <= idx_d;
        acc_q <= acc_d;
    end

    assign in_rdy     = (state_q == S_IDLE);
    assign out_vld    = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_ovf    = ovf_q;
    assign out_unf    = unf_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_bcd_price_alu.sv
// Directed bench for bcd_price_alu at the default 3.2 digit layout.
module tb_bcd_price_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic        in_op;
    logic [19:0] in_a;
    logic [19:0] in_b;
    logic        out_vld;
    logic        out_rdy;
    logic [19:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_err;

    int errors = 0;
    int checks = 0;

    bcd_price_alu #(.DOLLAR_N(3), .CENT_N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_result(out_result),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Presents one request, waits for the accept edge, then returns the cycle number
    // (1 = first cycle after the accept edge) at which out_vld was seen, or -1 on timeout.
    task automatic do_op(input logic op, input logic [19:0] a, input logic [19:0] b, output int lat);
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        in_a   = '1;
        in_b   = '1;
        in_op  = ~op;
        lat    = -1;
        for (int k = 1; k <= 20; k++) begin
            if (out_vld) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic finish_handshake();
        out_rdy = 1'b1;
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++; if (out_result !== 20'h00000) begin errors++; $display("FAIL reset_result got=%h exp=00000", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {out_ovf, out_unf, out_err}); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        do_op(1'b0, 20'h12345, 20'h00155, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL add_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h12500) begin errors++; $display("FAIL add_result got=%h exp=12500", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b exp=000", {out_ovf, out_unf, out_err}); end
        finish_handshake();
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL add_release_in_rdy got=%b exp=1", in_rdy); end
        checks++; if ({out_vld, out_ovf, out_unf, out_err} !== 4'b0000) begin errors++; $display("FAIL add_release_idle got=%b exp=0000", {out_vld, out_ovf, out_unf, out_err}); end
    endtask

    task automatic test_overflow_and_sub();
        int lat;
        do_op(1'b0, 20'h99999, 20'h00001, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL ovf_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h99999) begin errors++; $display("FAIL ovf_result got=%h exp=99999", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b100) begin errors++; $display("FAIL ovf_flags got=%b exp=100", {out_ovf, out_unf, out_err}); end
        finish_handshake();
        do_op(1'b1, 20'h10000, 20'h00001, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL sub_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h09999) begin errors++; $display("FAIL sub_result got=%h exp=09999", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b000) begin errors++; $display("FAIL sub_flags got=%b exp=000", {out_ovf, out_unf, out_err}); end
        finish_handshake();
    endtask

    task automatic test_underflow();
        int lat;
        do_op(1'b1, 20'h00001, 20'h00002, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL unf_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h00000) begin errors++; $display("FAIL unf_result got=%h exp=00000", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b010) begin errors++; $display("FAIL unf_flags got=%b exp=010", {out_ovf, out_unf, out_err}); end
        finish_handshake();
    endtask

    task automatic test_error();
        int lat;
        do_op(1'b0, 20'h0000A, 20'h00100, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL err_a_latency got=%0d exp=1", lat); end
        checks++; if (out_result !== 20'h00000) begin errors++; $display("FAIL err_a_result got=%h exp=00000", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b001) begin errors++; $display("FAIL err_a_flags got=%b exp=001", {out_ovf, out_unf, out_err}); end
        finish_handshake();
        do_op(1'b1, 20'h50000, 20'h00B00, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL err_b_latency got=%0d exp=1", lat); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b001) begin errors++; $display("FAIL err_b_flags got=%b exp=001", {out_ovf, out_unf, out_err}); end
        finish_handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(1'b0, 20'h20050, 20'h30025, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++; if ({out_vld, in_rdy} !== 2'b10) begin errors++; $display("FAIL bp_hold_handshake cyc=%0d got=%b exp=10", k, {out_vld, in_rdy}); end
            checks++; if (out_result !== 20'h50075) begin errors++; $display("FAIL bp_hold_result cyc=%0d got=%h exp=50075", k, out_result); end
            checks++; if ({out_ovf, out_unf, out_err} !== 3'b000) begin errors++; $display("FAIL bp_hold_flags cyc=%0d got=%b exp=000", k, {out_ovf, out_unf, out_err}); end
        end
        finish_handshake();
        checks++; if ({out_vld, in_rdy} !== 2'b01) begin errors++; $display("FAIL bp_release got=%b exp=01", {out_vld, in_rdy}); end
    endtask

    task automatic test_reset_mid_calc();
        in_op  = 1'b0;
        in_a   = 20'h12345;
        in_b   = 20'h11111;
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if ({out_vld, in_rdy} !== 2'b01) begin errors++; $display("FAIL rst_calc_state got=%b exp=01", {out_vld, in_rdy}); end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_calc_no_output cyc=%0d got=%b exp=0", k, out_vld); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        out_rdy = 1'b1;
        do_op(1'b1, 20'h50000, 20'h49999, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h00001) begin errors++; $display("FAIL b2b_first_result got=%h exp=00001", out_result); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL b2b_done_in_rdy got=%b exp=0", in_rdy); end
        @(posedge clk);
        #1;
        checks++; if ({out_vld, in_rdy} !== 2'b01) begin errors++; $display("FAIL b2b_idle got=%b exp=01", {out_vld, in_rdy}); end
        do_op(1'b0, 20'h00999, 20'h00001, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=6", lat); end
        checks++; if (out_result !== 20'h01000) begin errors++; $display("FAIL b2b_second_result got=%h exp=01000", out_result); end
        checks++; if ({out_ovf, out_unf, out_err} !== 3'b000) begin errors++; $display("FAIL b2b_second_flags got=%b exp=000", {out_ovf, out_unf, out_err}); end
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        checks++; if ({out_vld, in_rdy} !== 2'b01) begin errors++; $display("FAIL b2b_end got=%b exp=01", {out_vld, in_rdy}); end
    endtask

    initial begin
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_op   = 1'b0;
        in_a    = '0;
        in_b    = '0;
        out_rdy = 1'b0;
        test_reset();
        test_add();
        test_overflow_and_sub();
        test_underflow();
        test_error();
        test_backpressure();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_price_alu.md
BCD_PRICE_ALU -- requirements
Module: bcd_price_alu

Interface
REQ-001 SHALL have parameter DOLLAR_N, default 3, number of dollar BCD digits.
REQ-002 SHALL have parameter CENT_N, default 2, number of cent BCD digits; N = DOLLAR_N+CENT_N, W = 4*N.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_vld  input  1  operation request valid.
REQ-006 SHALL have port in_rdy  output  1  block can accept a request.
REQ-007 SHALL have port in_op  input  1  0 = add, 1 = subtract (a-b).
REQ-008 SHALL have port in_a  input  W  operand A, dollar digits MSB-side, cents LSB-side.
REQ-009 SHALL have port in_b  input  W  operand B, same layout.
REQ-010 SHALL have port out_vld  output  1  result valid.
REQ-011 SHALL have port out_rdy  input  1  consumer accepts result.
REQ-012 SHALL have port out_result  output  W  BCD result, same layout.
REQ-013 SHALL have port out_ovf  output  1  add overflowed; result saturated to all-9s.
REQ-014 SHALL have port out_unf  output  1  subtract underflowed; result clamped to zero.
REQ-015 SHALL have port out_err  output  1  operand contained a digit greater than 9.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; in_rdy = 1 only in IDLE.
REQ-017 SHALL, on in_vld && in_rdy, latch in_a, in_b, in_op, and clear carry/borrow and digit index.
REQ-018 SHALL, at accept, check all 2N operand digits; any digit > 9 -> go directly to DONE with out_err=1, result 0, ovf=unf=0.
REQ-019 SHALL otherwise go to CALC and process one digit per cycle, least-significant cent digit first, for exactly N cycles.
REQ-020 SHALL per add digit: s = a+b+c; s > 9 -> digit s-10, c=1; else digit s, c=0.
REQ-021 SHALL per subtract digit: d = a-b-br; d < 0 -> digit d+10, br=1; else digit d, br=0.
REQ-022 SHALL, after digit N-1, enter DONE; final carry=1 -> result all 9s, out_ovf=1; final borrow=1 -> result 0, out_unf=1.
REQ-023 SHALL assert out_vld in the cycle N+1 after the accept edge (error path: the cycle after accept).
REQ-024 SHALL hold out_vld, out_result and flags stable while out_vld && !out_rdy.
REQ-025 SHALL return to IDLE on out_vld && out_rdy; no accept in that same cycle (throughput one op per N+2 cycles minimum).
REQ-026 SHALL keep flags mutually exclusive and all zero whenever out_vld = 0.
REQ-027 SHALL ignore in_a/in_b/in_op changes after accept.

Reset
REQ-028 SHALL, with rst high at a clock edge, enter IDLE: in_rdy=1, out_vld=0, out_result=0, out_ovf=out_unf=out_err=0.
REQ-029 SHALL, on reset mid-CALC or mid-DONE, discard the operation with no output produced.

Structure
REQ-030 SHALL take char_t from bcd_pkg; bcd_pkg SHALL gain CHAR_MAX (9) and op_t enum {OP_ADD, OP_SUB}.
REQ-031 SHALL place the combinational single-digit add/subtract with carry/borrow in sub-module bcd_digit_addsub.
REQ-032 SHALL keep N-dependent types local to the module; the package stays parameter-free.

Verification (defaults DOLLAR_N=3, CENT_N=2)
REQ-033 SHALL test add 123.45 + 001.55 -> 125.00, flags 0, out_vld exactly 6 cycles after accept.
REQ-034 SHALL test add 999.99 + 000.01 -> 999.99, out_ovf=1; sub 100.00 - 000.01 -> 099.99, flags 0.
REQ-035 SHALL test sub 000.01 - 000.02 -> 000.00, out_unf=1.
REQ-036 SHALL test in_a digit 0xA -> out_err=1, result 0, out_vld the cycle after accept.
REQ-037 SHALL test out_rdy low 4 cycles in DONE -> outputs stable, in_rdy=0; then handshake -> in_rdy=1 next cycle.
REQ-038 SHALL test rst pulse in 3rd CALC cycle -> out_vld stays 0, in_rdy=1 the cycle after reset.
